// File: rtl/ram_ctrl_pkg.sv
// Shared widths, FSM encodings and handshake helper for ram_controller_arb.
package ram_ctrl_pkg;

    localparam int WORD_W      = 32;
    localparam int MCR_W       = 49;
    localparam int BUS_W       = 64;
    localparam int VRAM_AW_DEF = 15;
    localparam int MCR_AW_DEF  = 14;
    localparam int MEM_AW_DEF  = 29;

    typedef enum logic [1:0] {
        V_IDLE   = 2'd0,
        V_ACCESS = 2'd1,
        V_ACK    = 2'd2
    } vram_state_t;

    typedef enum logic [2:0] {
        S_WAIT_CAL = 3'd0,
        S_IDLE     = 3'd1,
        S_CMD      = 3'd2,
        S_RDWAIT   = 3'd3,
        S_ACK      = 3'd4
    } sdram_state_t;

    // Four-phase sequencer: ACK is held until the requester lets go.
    function automatic vram_state_t hs_next(
        vram_state_t s,
        logic        start,
        logic        hold
    );
        vram_state_t n;
        n = V_IDLE;
        case (s)
            V_IDLE:   n = start ? V_ACCESS : V_IDLE;
            V_ACCESS: n = V_ACK;
            V_ACK:    n = hold ? V_ACK : V_IDLE;
            default:  n = V_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ram_controller_arb_if.sv
// Request/response and external-bus signals of ram_controller_arb.
interface ram_controller_arb_if
    import ram_ctrl_pkg::*;
#(
    parameter int VRAM_AW = VRAM_AW_DEF,
    parameter int MCR_AW  = MCR_AW_DEF,
    parameter int MEM_AW  = MEM_AW_DEF
) ();

    logic                prefetch;
    logic                fetch;
    logic                machrun;
    logic [MCR_AW-1:0]   mcr_addr;
    logic [MCR_W-1:0]    mcr_data_in;
    logic                mcr_write;
    logic [MCR_W-1:0]    mcr_data_out;
    logic                mcr_ready;
    logic                mcr_done;
    logic [21:0]         sdram_addr;
    logic [WORD_W-1:0]   sdram_data_in;
    logic                sdram_req;
    logic                sdram_write;
    logic [WORD_W-1:0]   sdram_data_out;
    logic                sdram_ready;
    logic                sdram_done;
    logic                sdram_calib_done;
    logic                mem_calib_done;
    logic                mem_busy;
    logic [MEM_AW-1:0]   mem_addr;
    logic [7:0]          mem_burstcnt;
    logic                mem_rd;
    logic                mem_we;
    logic [BUS_W-1:0]    mem_din;
    logic [7:0]          mem_be;
    logic [BUS_W-1:0]    mem_dout;
    logic                mem_dout_ready;
    logic [VRAM_AW-1:0]  vram_cpu_addr;
    logic [WORD_W-1:0]   vram_cpu_data_in;
    logic                vram_cpu_req;
    logic                vram_cpu_write;
    logic [WORD_W-1:0]   vram_cpu_data_out;
    logic                vram_cpu_ready;
    logic                vram_cpu_done;
    logic [VRAM_AW-1:0]  vram_vga_addr;
    logic                vram_vga_req;
    logic [WORD_W-1:0]   vram_vga_data_out;
    logic                vram_vga_ready;

    modport slave (
        input  prefetch, fetch, machrun,
        input  mcr_addr, mcr_data_in, mcr_write,
        output mcr_data_out, mcr_ready, mcr_done,
        input  sdram_addr, sdram_data_in, sdram_req, sdram_write,
        output sdram_data_out, sdram_ready, sdram_done, sdram_calib_done,
        input  mem_calib_done, mem_busy, mem_dout, mem_dout_ready,
        output mem_addr, mem_burstcnt, mem_rd, mem_we, mem_din, mem_be,
        input  vram_cpu_addr, vram_cpu_data_in, vram_cpu_req, vram_cpu_write,
        output vram_cpu_data_out, vram_cpu_ready, vram_cpu_done,
        input  vram_vga_addr, vram_vga_req,
        output vram_vga_data_out, vram_vga_ready
    );

    modport master (
        output prefetch, fetch, machrun,
        output mcr_addr, mcr_data_in, mcr_write,
        input  mcr_data_out, mcr_ready, mcr_done,
        output sdram_addr, sdram_data_in, sdram_req, sdram_write,
        input  sdram_data_out, sdram_ready, sdram_done, sdram_calib_done,
        output mem_calib_done, mem_busy, mem_dout, mem_dout_ready,
        input  mem_addr, mem_burstcnt, mem_rd, mem_we, mem_din, mem_be,
        output vram_cpu_addr, vram_cpu_data_in, vram_cpu_req, vram_cpu_write,
        input  vram_cpu_data_out, vram_cpu_ready, vram_cpu_done,
        output vram_vga_addr, vram_vga_req,
        input  vram_vga_data_out, vram_vga_ready
    );

endinterface

// File: rtl/vram_dpram.sv
// True dual-port RAM, read-first, registered outputs; the array itself is never reset.
module vram_dpram #(
    parameter int DW = 32,
    parameter int AW = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_a_i,
    input  logic          we_a_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [DW-1:0] d_a_i,
    output logic [DW-1:0] q_a_o,
    input  logic          en_b_i,
    input  logic          we_b_i,
    input  logic [AW-1:0] addr_b_i,
    input  logic [DW-1:0] d_b_i,
    output logic [DW-1:0] q_b_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] q_a_q;
    logic [DW-1:0] q_b_q;

    always_ff @(posedge clk_i) begin
        if (we_a_i) begin
            mem_q[addr_a_i] <= d_a_i;
        end
        if (we_b_i) begin
            mem_q[addr_b_i] <= d_b_i;
        end
    end

    // Reads sample the array before this edge's writes land.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            if (en_a_i) begin
                q_a_q <= mem_q[addr_a_i];
            end
            if (en_b_i) begin
                q_b_q <= mem_q[addr_b_i];
            end
        end
    end

    assign q_a_o = q_a_q;
    assign q_b_o = q_b_q;

endmodule

// File: rtl/ram_controller_arb.sv
// CPU/VGA memory arbiter: dual-port VRAM, 32->64-bit sdram bridge, microcode RAM.
// Define RAM_CTRL_MCR_EN to build the microcode array; otherwise writes are only acknowledged.
module ram_controller_arb
    import ram_ctrl_pkg::*;
#(
    parameter int VRAM_AW = VRAM_AW_DEF,
    parameter int MCR_AW  = MCR_AW_DEF,
    parameter int MEM_AW  = MEM_AW_DEF
) (
    input  logic sdram_clk,
    input  logic reset,
    ram_controller_arb_if.slave bus
);

    vram_state_t        vc_q, vc_d;
    vram_state_t        vg_q, vg_d;
    logic               vc_wr_q;
    logic               vc_start;
    logic [VRAM_AW-1:0] vc_addr_q;
    logic [VRAM_AW-1:0] vg_addr_q;
    logic [WORD_W-1:0]  vc_din_q;
    logic [WORD_W-1:0]  vc_rd;
    logic [WORD_W-1:0]  vg_rd;

    assign vc_start = bus.vram_cpu_req | bus.vram_cpu_write;

    always_comb begin
        vc_d = hs_next(vc_q, vc_start,
                       vc_wr_q ? bus.vram_cpu_write : bus.vram_cpu_req);
        vg_d = hs_next(vg_q, bus.vram_vga_req, bus.vram_vga_req);
    end

    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            vc_q      <= V_IDLE;
            vg_q      <= V_IDLE;
            vc_wr_q   <= 1'b0;
            vc_addr_q <= '0;
            vg_addr_q <= '0;
            vc_din_q  <= '0;
        end else begin
            vc_q <= vc_d;
            vg_q <= vg_d;
            if (vc_q == V_IDLE && vc_start) begin
                vc_wr_q   <= bus.vram_cpu_write;
                vc_addr_q <= bus.vram_cpu_addr;
                vc_din_q  <= bus.vram_cpu_data_in;
            end
            if (vg_q == V_IDLE && bus.vram_vga_req) begin
                vg_addr_q <= bus.vram_vga_addr;
            end
        end
    end

    vram_dpram #(.DW(WORD_W), .AW(VRAM_AW)) u_vram (
        .clk_i    (sdram_clk),
        .rst_i    (reset),
        .en_a_i   (vc_q == V_ACCESS && !vc_wr_q),
        .we_a_i   (vc_q == V_ACCESS && vc_wr_q),
        .addr_a_i (vc_addr_q),
        .d_a_i    (vc_din_q),
        .q_a_o    (vc_rd),
        .en_b_i   (vg_q == V_ACCESS),
        .we_b_i   (1'b0),
        .addr_b_i (vg_addr_q),
        .d_b_i    ('0),
        .q_b_o    (vg_rd)
    );

    assign bus.vram_cpu_data_out = vc_rd;
    assign bus.vram_cpu_ready    = (vc_q == V_ACK) && !vc_wr_q;
    assign bus.vram_cpu_done     = (vc_q == V_ACK) && vc_wr_q;
    assign bus.vram_vga_data_out = vg_rd;
    assign bus.vram_vga_ready    = (vg_q == V_ACK);

    sdram_state_t      sd_q, sd_d;
    logic              cal_q;
    logic              sd_wr_q;
    logic              sd_hi_q;
    logic              sd_start;
    logic [MEM_AW-1:0] ma_q;
    logic [BUS_W-1:0]  din_q;
    logic [7:0]        be_q;
    logic [WORD_W-1:0] rdata_q;

    assign sd_start = bus.sdram_req | bus.sdram_write;

    always_comb begin
        sd_d = sd_q;
        unique case (sd_q)
            S_WAIT_CAL: if (cal_q) sd_d = S_IDLE;
            S_IDLE:     if (sd_start) sd_d = S_CMD;
            S_CMD: begin
                if (!bus.mem_busy) begin
                    sd_d = sd_wr_q ? S_ACK : S_RDWAIT;
                end
            end
            S_RDWAIT:   if (bus.mem_dout_ready) sd_d = S_ACK;
            S_ACK: begin
                if (!(sd_wr_q ? bus.sdram_write : bus.sdram_req)) begin
                    sd_d = S_IDLE;
                end
            end
            default:    sd_d = S_WAIT_CAL;
        endcase
    end

    // Even word addresses sit in the low half of a 64-bit beat.
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            sd_q    <= S_WAIT_CAL;
            cal_q   <= 1'b0;
            sd_wr_q <= 1'b0;
            sd_hi_q <= 1'b0;
            ma_q    <= '0;
            din_q   <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            sd_q  <= sd_d;
            cal_q <= bus.mem_calib_done;
            if (sd_q == S_IDLE && sd_start) begin
                sd_wr_q <= bus.sdram_write;
                sd_hi_q <= bus.sdram_addr[0];
                ma_q    <= MEM_AW'(bus.sdram_addr[21:1]);
                din_q   <= {bus.sdram_data_in, bus.sdram_data_in};
                be_q    <= bus.sdram_write
                         ? (bus.sdram_addr[0] ? 8'hF0 : 8'h0F)
                         : 8'hFF;
            end
            if (sd_q == S_RDWAIT && bus.mem_dout_ready) begin
                rdata_q <= sd_hi_q ? bus.mem_dout[63:32]
                                   : bus.mem_dout[31:0];
            end
        end
    end

    assign bus.sdram_calib_done = cal_q;
    assign bus.sdram_data_out   = rdata_q;
    assign bus.sdram_ready      = (sd_q == S_ACK) && !sd_wr_q;
    assign bus.sdram_done       = (sd_q == S_ACK) && sd_wr_q;
    assign bus.mem_rd           = (sd_q == S_CMD) && !sd_wr_q;
    assign bus.mem_we           = (sd_q == S_CMD) && sd_wr_q;
    assign bus.mem_burstcnt     = {7'd0, sd_q == S_CMD};
    assign bus.mem_addr         = ma_q;
    assign bus.mem_din          = din_q;
    assign bus.mem_be           = be_q;

    vram_state_t mc_q, mc_d;
    logic        mrdy_q;

    always_comb begin
        mc_d = hs_next(mc_q, bus.mcr_write, bus.mcr_write);
    end

    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            mc_q   <= V_IDLE;
            mrdy_q <= 1'b0;
        end else begin
            mc_q   <= mc_d;
            mrdy_q <= bus.fetch & bus.machrun;
        end
    end

    assign bus.mcr_done  = (mc_q == V_ACK);
    assign bus.mcr_ready = mrdy_q;

`ifdef RAM_CTRL_MCR_EN
    logic [MCR_AW-1:0] mc_addr_q;
    logic [MCR_W-1:0]  mc_din_q;
    logic [MCR_W-1:0]  mc_rd;
    logic [MCR_W-1:0]  mc_qa_unused;

    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            mc_addr_q <= '0;
            mc_din_q  <= '0;
        end else if (mc_q == V_IDLE && bus.mcr_write) begin
            mc_addr_q <= bus.mcr_addr;
            mc_din_q  <= bus.mcr_data_in;
        end
    end

    vram_dpram #(.DW(MCR_W), .AW(MCR_AW)) u_mcr (
        .clk_i    (sdram_clk),
        .rst_i    (reset),
        .en_a_i   (1'b0),
        .we_a_i   (mc_q == V_ACCESS),
        .addr_a_i (mc_addr_q),
        .d_a_i    (mc_din_q),
        .q_a_o    (mc_qa_unused),
        .en_b_i   (bus.prefetch),
        .we_b_i   (1'b0),
        .addr_b_i (bus.mcr_addr),
        .d_b_i    ('0),
        .q_b_o    (mc_rd)
    );

    assign bus.mcr_data_out = mc_rd;
`else
    logic [MCR_AW-1:0] mcr_addr_unused;
    logic [MCR_W-1:0]  mcr_din_unused;
    logic              mcr_pf_unused;

    assign mcr_addr_unused  = bus.mcr_addr;
    assign mcr_din_unused   = bus.mcr_data_in;
    assign mcr_pf_unused    = bus.prefetch;
    assign bus.mcr_data_out = '0;
`endif

endmodule

// File: tb/tb_ram_controller_arb.sv
// Directed plus randomized bench for ram_controller_arb with a word-level reference model.
module tb_ram_controller_arb;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [31:0] vm [int];
    logic [31:0] sm [int];
    logic [63:0] bmem [int];

    ram_controller_arb_if bus ();

    ram_controller_arb dut (
        .sdram_clk (clk),
        .reset     (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sm_get(input int a);
        return sm.exists(a) ? sm[a] : 32'h0;
    endfunction

    // External memory: 3 stall cycles per command, delayed read data.
    initial begin
        int          ma;
        logic [63:0] md;
        logic [63:0] beat;
        logic [7:0]  mb;
        bit          rd;
        bus.mem_busy       = 1'b0;
        bus.mem_dout_ready = 1'b0;
        bus.mem_dout       = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1 || bus.mem_rd === 1'b1) begin
                rd = bus.mem_rd;
                ma = int'(bus.mem_addr);
                md = bus.mem_din;
                mb = bus.mem_be;
                bus.mem_busy = 1'b1;
                repeat (3) @(negedge clk);
                bus.mem_busy = 1'b0;
                @(negedge clk);
                beat = bmem.exists(ma) ? bmem[ma] : 64'h0;
                if (!rd) begin
                    for (int b = 0; b < 8; b++) begin
                        if (mb[b]) beat[8*b +: 8] = md[8*b +: 8];
                    end
                    bmem[ma] = beat;
                end else begin
                    repeat (3) @(negedge clk);
                    bus.mem_dout       = beat;
                    bus.mem_dout_ready = 1'b1;
                    @(negedge clk);
                    bus.mem_dout_ready = 1'b0;
                    bus.mem_dout       = {$urandom, $urandom};
                end
            end
        end
    end

    task automatic vc_write(input int a, input logic [31:0] d);
        bus.vram_cpu_addr    = 15'(a);
        bus.vram_cpu_data_in = d;
        bus.vram_cpu_write   = 1'b1;
        @(negedge clk);
        check("vc_wr_done_t1", bus.vram_cpu_done, 1'b0);
        @(negedge clk);
        check("vc_wr_done_t2", bus.vram_cpu_done, 1'b1);
        bus.vram_cpu_write = 1'b0;
        @(negedge clk);
        check("vc_wr_release", bus.vram_cpu_done, 1'b0);
        vm[a] = d;
    endtask

    task automatic vc_read(input int a);
        bus.vram_cpu_addr = 15'(a);
        bus.vram_cpu_req  = 1'b1;
        @(negedge clk);
        check("vc_rd_ready_t1", bus.vram_cpu_ready, 1'b0);
        @(negedge clk);
        check("vc_rd_ready_t2", bus.vram_cpu_ready, 1'b1);
        check("vc_rd_data", bus.vram_cpu_data_out, vm[a]);
        @(negedge clk);
        check("vc_rd_hold", bus.vram_cpu_data_out, vm[a]);
        bus.vram_cpu_req = 1'b0;
        @(negedge clk);
        check("vc_rd_release", bus.vram_cpu_ready, 1'b0);
    endtask

    task automatic vg_read(input int a);
        bus.vram_vga_addr = 15'(a);
        bus.vram_vga_req  = 1'b1;
        @(negedge clk);
        check("vg_rd_ready_t1", bus.vram_vga_ready, 1'b0);
        @(negedge clk);
        check("vg_rd_ready_t2", bus.vram_vga_ready, 1'b1);
        check("vg_rd_data", bus.vram_vga_data_out, vm[a]);
        bus.vram_vga_req = 1'b0;
        @(negedge clk);
        check("vg_rd_release", bus.vram_vga_ready, 1'b0);
    endtask

    task automatic sd_write(input int a, input logic [31:0] d, input bit both);
        int n;
        bus.sdram_addr    = 22'(a);
        bus.sdram_data_in = d;
        bus.sdram_write   = 1'b1;
        bus.sdram_req     = both;
        n = 0;
        while (bus.sdram_done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("sd_wr_done", bus.sdram_done, 1'b1);
        check("sd_wr_noready", bus.sdram_ready, 1'b0);
        bus.sdram_write = 1'b0;
        bus.sdram_req   = 1'b0;
        @(negedge clk);
        check("sd_wr_release", bus.sdram_done, 1'b0);
        sm[a] = d;
    endtask

    task automatic sd_read(input int a);
        int n;
        bus.sdram_addr = 22'(a);
        bus.sdram_req  = 1'b1;
        n = 0;
        while (bus.sdram_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("sd_rd_ready", bus.sdram_ready, 1'b1);
        check("sd_rd_data", bus.sdram_data_out, sm_get(a));
        @(negedge clk);
        check("sd_rd_hold", bus.sdram_data_out, sm_get(a));
        bus.sdram_req = 1'b0;
        @(negedge clk);
        check("sd_rd_release", bus.sdram_ready, 1'b0);
    endtask

    initial begin
        int          a;
        int          op;
        int          n;
        bit          saw;
        logic [48:0] mexp;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.prefetch = 0;
        bus.fetch = 0;
        bus.machrun = 0;
        bus.mcr_addr = '0;
        bus.mcr_data_in = '0;
        bus.mcr_write = 0;
        bus.sdram_addr = '0;
        bus.sdram_data_in = '0;
        bus.sdram_req = 0;
        bus.sdram_write = 0;
        bus.mem_calib_done = 0;
        bus.vram_cpu_addr = '0;
        bus.vram_cpu_data_in = '0;
        bus.vram_cpu_req = 0;
        bus.vram_cpu_write = 0;
        bus.vram_vga_addr = '0;
        bus.vram_vga_req = 0;
        repeat (3) @(negedge clk);
        check("rst_vram_flags", {bus.vram_cpu_ready, bus.vram_cpu_done,
                                 bus.vram_vga_ready}, 3'b000);
        check("rst_sd_flags", {bus.sdram_ready, bus.sdram_done,
                               bus.sdram_calib_done}, 3'b000);
        check("rst_mem_cmd", {bus.mem_rd, bus.mem_we, bus.mem_burstcnt}, 10'd0);
        check("rst_mem_addr_be", {bus.mem_addr, bus.mem_be}, 37'd0);
        check("rst_mem_din", bus.mem_din, 64'd0);
        check("rst_mcr", {bus.mcr_ready, bus.mcr_done}, 2'b00);
        check("rst_mcr_data", bus.mcr_data_out, 49'd0);
        rst = 1'b0;
        @(negedge clk);

        vc_write(100, 32'o12345670);
        vc_write(102, 32'o22222222);
        vc_write(104, 32'o33333333);
        vc_read(100);
        vc_read(102);
        vc_read(104);
        vg_read(100);
        vg_read(102);
        vg_read(104);

        // Same-cycle CPU write and VGA read of one word: VGA sees old data.
        bus.vram_cpu_addr    = 15'd100;
        bus.vram_cpu_data_in = 32'hFFFF_FFFF;
        bus.vram_cpu_write   = 1'b1;
        bus.vram_vga_addr    = 15'd100;
        bus.vram_vga_req     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("coll_vga_ready", bus.vram_vga_ready, 1'b1);
        check("coll_vga_old", bus.vram_vga_data_out, 32'o12345670);
        check("coll_cpu_done", bus.vram_cpu_done, 1'b1);
        bus.vram_cpu_write = 1'b0;
        bus.vram_vga_req   = 1'b0;
        @(negedge clk);
        vm[100] = 32'hFFFF_FFFF;
        vc_read(100);
        vg_read(100);

        for (int i = 0; i < 24; i++) begin
            a  = 300 + int'($urandom_range(0, 7));
            op = int'($urandom_range(0, 2));
            if (op == 0 || !vm.exists(a)) vc_write(a, $urandom);
            else if (op == 1) vc_read(a);
            else vg_read(a);
        end

        // Sdram port is gated until calibration is reported.
        bus.sdram_addr    = 22'd1;
        bus.sdram_data_in = 32'o10101111;
        bus.sdram_write   = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.mem_we === 1'b1 || bus.mem_rd === 1'b1) saw = 1'b1;
        end
        check("nocal_no_cmd", saw, 1'b0);
        check("nocal_flag", bus.sdram_calib_done, 1'b0);
        bus.mem_calib_done = 1'b1;
        #1;
        check("cal_registered", bus.sdram_calib_done, 1'b0);
        n = 0;
        while (bus.mem_we !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cal_flag", bus.sdram_calib_done, 1'b1);
        check("cal_we", bus.mem_we, 1'b1);
        check("cal_addr", bus.mem_addr, 29'd0);
        check("cal_be", bus.mem_be, 8'hF0);
        check("cal_din_hi", bus.mem_din[63:32], 32'o10101111);
        check("cal_burst", bus.mem_burstcnt, 8'd1);
        n = 0;
        while (bus.sdram_done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("cal_wr_done", bus.sdram_done, 1'b1);
        bus.sdram_write = 1'b0;
        @(negedge clk);
        check("cal_wr_release", bus.sdram_done, 1'b0);
        sm[1] = 32'o10101111;

        sd_write(0, 32'o0, 1'b0);
        sd_write(2, 32'o20202222, 1'b0);
        sd_write(4, 32'o30303333, 1'b0);
        sd_read(0);
        sd_read(1);
        sd_read(2);
        sd_read(4);

        for (int i = 0; i < 12; i++) begin
            a = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                sd_write(a, $urandom, 1'($urandom_range(0, 1)));
            end else begin
                sd_read(a);
            end
        end

        // Reset while the bridge waits for read data.
        bus.sdram_addr = 22'd4;
        bus.sdram_req  = 1'b1;
        n = 0;
        while (bus.mem_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.mem_rd === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.mem_calib_done = 1'b0;
        rst = 1'b1;
        #1;
        check("rrst_mem_rd", bus.mem_rd, 1'b0);
        check("rrst_ready", bus.sdram_ready, 1'b0);
        check("rrst_cal", bus.sdram_calib_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_rd === 1'b1 || bus.sdram_ready === 1'b1) saw = 1'b1;
        end
        check("rrst_waits_cal", saw, 1'b0);
        bus.mem_calib_done = 1'b1;
        sd_read(4);

        bus.mcr_addr    = 14'd2;
        bus.mcr_data_in = 49'o333300003333;
        bus.mcr_write   = 1'b1;
        @(negedge clk);
        check("mcr_done_t1", bus.mcr_done, 1'b0);
        @(negedge clk);
        check("mcr_done_t2", bus.mcr_done, 1'b1);
        bus.mcr_write = 1'b0;
        @(negedge clk);
        check("mcr_done_release", bus.mcr_done, 1'b0);
`ifdef RAM_CTRL_MCR_EN
        mexp = 49'o333300003333;
`else
        mexp = 49'd0;
`endif
        bus.prefetch = 1'b1;
        @(negedge clk);
        bus.prefetch = 1'b0;
        bus.mcr_addr = 14'd3;
        bus.fetch    = 1'b1;
        @(negedge clk);
        check("mcr_ready_nomach", bus.mcr_ready, 1'b0);
        bus.machrun = 1'b1;
        @(negedge clk);
        check("mcr_ready", bus.mcr_ready, 1'b1);
        check("mcr_data", bus.mcr_data_out, mexp);
        bus.fetch   = 1'b0;
        bus.machrun = 1'b0;
        @(negedge clk);
        check("mcr_ready_drop", bus.mcr_ready, 1'b0);
        check("mcr_data_hold", bus.mcr_data_out, mexp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
